reg_pipeline: RTL and testbench
===============================

REG_PIPELINE -- requirements
Module: reg_pipeline

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits, legal range >= 1.
REQ-002 Parameter DEPTH, default 2, number of register stages, legal range >= 1.
REQ-003 Derived constant CNT_W = clog2(DEPTH+1), width of the occupancy output.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block accepts the word this cycle.
REQ-008 in_data  input  WIDTH  upstream word.
REQ-009 out_valid  output  1  word present at the output stage.
REQ-010 out_ready  input  1  downstream accepts the word this cycle.
REQ-011 out_data  output  WIDTH  word held in the last stage.
REQ-012 flush  input  1  synchronous discard of all held words.
REQ-013 occupancy  output  CNT_W  number of stages holding a valid word.

Function
REQ-014 The block SHALL hold stage registers v[k] and d[k], k = 0..DEPTH-1, with stage 0 nearest the input.
REQ-015 A transfer into a stage SHALL occur only when the source valid and the stage ready are both 1 in the same cycle.
REQ-016 Stage ready SHALL be r[k] = !v[k] || r[k+1], with r[DEPTH] = out_ready, so an empty stage accepts even under downstream stall.
REQ-017 in_ready SHALL equal r[0] && !flush.
REQ-018 out_valid SHALL equal v[DEPTH-1] && !flush, and out_data SHALL equal d[DEPTH-1].
REQ-019 On an edge with r[k]=1 and no flush, v[k] SHALL load the upstream valid (in_valid for k=0, v[k-1] otherwise).
REQ-020 d[k] SHALL load upstream data only on a transfer into stage k and SHALL otherwise hold its value.
REQ-021 With out_ready held at 1, latency SHALL be exactly DEPTH cycles from the in_valid && in_ready edge to out_valid, at a sustained throughput of one word per cycle.
REQ-022 Words SHALL leave in acceptance order, with no loss and no duplication.
REQ-023 Bubbles SHALL collapse: a stalled block with E empty stages SHALL accept E further words before in_ready falls.
REQ-024 Full condition: all v[k]=1 and out_ready=0 SHALL give in_ready=0; a full block with out_ready=1 SHALL accept and emit in the same cycle.
REQ-025 flush=1 SHALL clear every v[k] on the next edge, accept no input, and emit no output in that cycle; d[k] SHALL be unchanged.
REQ-026 occupancy SHALL be the registered population count of v[], range 0..DEPTH, updated on every edge.
REQ-027 in_ready SHALL be combinational from out_ready and flush only, and out_valid SHALL be combinational from flush only, so no other input-to-output combinational path exists.
REQ-028 in_valid=0 SHALL never cause a transfer, whatever the in_data value.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force all v[k]=0, all d[k]=0, occupancy=0, out_valid=0 and out_data=0.
REQ-030 in_ready SHALL read 1 during reset only if flush=0, as given by REQ-016/017 with all stages empty.
REQ-031 Reset asserted mid-stream SHALL discard all held words, and the first edge after release SHALL behave as an empty block.

Structure
REQ-032 A shared package reg_pipeline_pkg SHALL hold the default WIDTH/DEPTH constants and the CNT_W clog2 function.
REQ-033 One sub-module, pipe_stage, SHALL implement a single v/d stage with its ready term, and SHALL be instantiated DEPTH times by a generate loop.
REQ-034 No latches SHALL be present, no wire SHALL be procedurally assigned, no reg SHALL be continuously assigned, and every declared signal SHALL be referenced.

Verification (WIDTH=8, DEPTH=3)
REQ-035 Reset: rst_n=0 asynchronously mid-cycle -> out_valid=0, out_data=0x00 and occupancy=0 before the next edge.
REQ-036 Stream: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> out_data is 0x11, 0x22, 0x33 on cycles 3, 4, 5 with out_valid continuously 1.
REQ-037 Stall: out_ready=0 and push 0x11..0x44 -> three words accepted, occupancy=3, in_ready=0 on 0x44; then out_ready=1 -> output order 0x11, 0x22, 0x33, 0x44.
REQ-038 Bubble: out_ready=0 and one word 0xA5 pushed -> 0xA5 reaches stage 2 after 3 cycles, occupancy=1, in_ready remains 1.
REQ-039 Flush: two words held and flush=1 together with in_valid=1 -> occupancy=0 next cycle, in_ready=0 and out_valid=0 during flush; a subsequent word 0x5A emerges after 3 cycles.
REQ-040 Full pass-through: full block with out_ready=1 and in_valid=1 -> one word accepted and one emitted per cycle, and occupancy stays 3.

Source files
------------

// File: rtl/reg_pipeline_pkg.sv
// Shared constants and helpers for the ready/valid register pipeline.
package reg_pipeline_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 2;

    // Bits needed to count 0..depth occupied stages.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register stage with bubble-collapsing ready term.
module pipe_stage
    import reg_pipeline_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             dn_ready_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic             valid_next_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic             ready;

    always_comb begin
        // An empty stage accepts even while everything downstream is stalled.
        ready   = !valid_q || dn_ready_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (ready) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign ready_o      = ready;
    assign valid_o      = valid_q;
    assign valid_next_o = valid_d;
    assign data_o       = data_q;

endmodule

// File: rtl/reg_pipeline.sv
// DEPTH-stage ready/valid register pipeline with flush and occupancy count.
module reg_pipeline
    import reg_pipeline_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] occupancy
);

    logic             stage_valid      [DEPTH];
    logic             stage_valid_next [DEPTH];
    logic [WIDTH-1:0] stage_data       [DEPTH];
    logic             stage_ready      [DEPTH+1];
    logic             up_valid         [DEPTH];
    logic [WIDTH-1:0] up_data          [DEPTH];
    logic [CNT_W-1:0] occ_d, occ_q;

    assign up_valid[0]        = in_valid;
    assign up_data[0]         = in_data;
    assign stage_ready[DEPTH] = out_ready;

    for (genvar k = 1; k < DEPTH; k++) begin : g_link
        assign up_valid[k] = stage_valid[k-1];
        assign up_data[k]  = stage_data[k-1];
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush_i     (flush),
            .up_valid_i  (up_valid[k]),
            .up_data_i   (up_data[k]),
            .dn_ready_i  (stage_ready[k+1]),
            .ready_o     (stage_ready[k]),
            .valid_o     (stage_valid[k]),
            .valid_next_o(stage_valid_next[k]),
            .data_o      (stage_data[k])
        );
    end

    // Count from next-state valids so the register always matches the stages it describes.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + CNT_W'(stage_valid_next[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign in_ready  = stage_ready[0] && !flush;
    assign out_valid = stage_valid[DEPTH-1] && !flush;
    assign out_data  = stage_data[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_reg_pipeline.sv
// Bench for reg_pipeline (WIDTH=8, DEPTH=3) against a word/position queue model.
module tb_reg_pipeline;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             flush = 1'b0;
    logic [1:0]       occupancy;

    int checks = 0;
    int errors = 0;

    // Model: words in acceptance order (oldest first) with their stage position.
    logic [WIDTH-1:0] m_data[$];
    int               m_pos[$];
    logic [WIDTH-1:0] m_tail = '0;
    int               plan_pos[DEPTH];
    bit               plan_pop;
    logic             exp_ir, exp_ov;
    logic [WIDTH-1:0] exp_od;
    logic [1:0]       exp_occ;

    reg_pipeline #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // A word moves forward when the slot ahead is free after the older word has moved.
    task automatic model_plan();
        int prev;
        prev     = DEPTH;
        plan_pop = 0;
        for (int i = 0; i < m_pos.size(); i++) begin
            if (i == 0 && m_pos[i] == DEPTH - 1 && out_ready) begin
                plan_pop    = 1;
                plan_pos[i] = DEPTH;
            end else begin
                plan_pos[i] = (m_pos[i] + 1 < prev) ? m_pos[i] + 1 : m_pos[i];
            end
            prev = plan_pos[i];
        end
        exp_ir  = !flush && (m_pos.size() == 0 || plan_pos[m_pos.size()-1] > 0);
        exp_ov  = !flush && m_pos.size() > 0 && m_pos[0] == DEPTH - 1;
        exp_od  = m_tail;
        exp_occ = 2'(m_pos.size());
    endtask

    task automatic set_inputs(input bit iv, input logic [WIDTH-1:0] id, input bit ordy,
                              input bit fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        model_plan();
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (flush) begin
            m_data.delete();
            m_pos.delete();
        end else begin
            for (int i = 0; i < m_pos.size(); i++) begin
                if (plan_pos[i] == DEPTH - 1 && m_pos[i] != DEPTH - 1) m_tail = m_data[i];
                m_pos[i] = plan_pos[i];
            end
            if (plan_pop) begin
                void'(m_pos.pop_front());
                void'(m_data.pop_front());
            end
            if (in_valid && exp_ir) begin
                m_pos.push_back(0);
                m_data.push_back(in_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (DEPTH + 1) begin
            set_inputs(1'b0, '0, 1'b1, 1'b0);
            clock_edge();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset.out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset.out_data got %h exp 00", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset.occupancy got %0d exp 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset.in_ready got %b exp 1", in_ready); end
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset.in_ready_flush got %b exp 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        set_inputs(1'b1, 8'hC3, 1'b0, 1'b0);
        clock_edge();
        set_inputs(1'b1, 8'h3C, 1'b0, 1'b0);
        clock_edge();
        set_inputs(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_data.delete();
        m_pos.delete();
        m_tail = '0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid.out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_mid.out_data got %h exp 00", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_mid.occupancy got %0d exp 0", occupancy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] words [3];
        words = '{8'h11, 8'h22, 8'h33};
        drain();
        for (int c = 0; c < 8; c++) begin
            set_inputs(c < 3, (c < 3) ? words[c] : 8'h00, 1'b1, 1'b0);
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL stream.in_ready c%0d got %b exp %b", c, in_ready, exp_ir); end
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL stream.out_valid c%0d got %b exp %b", c, out_valid, exp_ov); end
            checks++; if (out_data !== exp_od) begin errors++; $display("FAIL stream.out_data c%0d got %h exp %h", c, out_data, exp_od); end
            checks++; if (occupancy !== exp_occ) begin errors++; $display("FAIL stream.occupancy c%0d got %0d exp %0d", c, occupancy, exp_occ); end
            if (c >= 3 && c <= 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== words[c-3]) begin
                    errors++;
                    $display("FAIL stream.word c%0d got %b/%h exp 1/%h", c, out_valid, out_data, words[c-3]);
                end
            end
            clock_edge();
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] words [4];
        logic [WIDTH-1:0] got[$];
        int idx;
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        idx = 0;
        drain();
        for (int c = 0; c < 13; c++) begin
            set_inputs(idx < 4, (idx < 4) ? words[idx] : 8'h00, c >= 4, 1'b0);
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL stall.in_ready c%0d got %b exp %b", c, in_ready, exp_ir); end
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL stall.out_valid c%0d got %b exp %b", c, out_valid, exp_ov); end
            checks++; if (out_data !== exp_od) begin errors++; $display("FAIL stall.out_data c%0d got %h exp %h", c, out_data, exp_od); end
            checks++; if (occupancy !== exp_occ) begin errors++; $display("FAIL stall.occupancy c%0d got %0d exp %0d", c, occupancy, exp_occ); end
            if (c == 3) begin
                checks++;
                if (occupancy !== 2'd3 || in_ready !== 1'b0 || in_data !== 8'h44) begin
                    errors++;
                    $display("FAIL stall.full got occ %0d rdy %b data %h exp occ 3 rdy 0 data 44", occupancy, in_ready, in_data);
                end
            end
            if (out_valid && out_ready) got.push_back(out_data);
            if (idx < 4 && exp_ir) idx++;
            clock_edge();
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL stall.count got %0d exp 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== words[i]) begin errors++; $display("FAIL stall.order[%0d] got %h exp %h", i, got[i], words[i]); end
            end
        end
    endtask

    task automatic test_bubble();
        drain();
        for (int c = 0; c < 5; c++) begin
            set_inputs(c == 0, 8'hA5, 1'b0, 1'b0);
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL bubble.in_ready c%0d got %b exp %b", c, in_ready, exp_ir); end
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL bubble.out_valid c%0d got %b exp %b", c, out_valid, exp_ov); end
            checks++; if (occupancy !== exp_occ) begin errors++; $display("FAIL bubble.occupancy c%0d got %0d exp %0d", c, occupancy, exp_occ); end
            if (c == 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'hA5 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bubble.stage2 got v%b d%h occ%0d rdy%b exp v1 dA5 occ1 rdy1", out_valid, out_data, occupancy, in_ready);
                end
            end
            clock_edge();
        end
    endtask

    task automatic test_flush();
        drain();
        for (int c = 0; c < 8; c++) begin
            case (c)
                0: set_inputs(1'b1, 8'h61, 1'b0, 1'b0);
                1: set_inputs(1'b1, 8'h62, 1'b0, 1'b0);
                2: set_inputs(1'b1, 8'h77, 1'b0, 1'b1);
                3: set_inputs(1'b1, 8'h5A, 1'b1, 1'b0);
                default: set_inputs(1'b0, 8'h00, 1'b1, 1'b0);
            endcase
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL flush.in_ready c%0d got %b exp %b", c, in_ready, exp_ir); end
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL flush.out_valid c%0d got %b exp %b", c, out_valid, exp_ov); end
            checks++; if (out_data !== exp_od) begin errors++; $display("FAIL flush.out_data c%0d got %h exp %h", c, out_data, exp_od); end
            checks++; if (occupancy !== exp_occ) begin errors++; $display("FAIL flush.occupancy c%0d got %0d exp %0d", c, occupancy, exp_occ); end
            if (c == 2) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b0 || occupancy !== 2'd2) begin
                    errors++;
                    $display("FAIL flush.during got rdy%b v%b occ%0d exp rdy0 v0 occ2", in_ready, out_valid, occupancy);
                end
            end
            if (c == 3) begin
                checks++;
                if (occupancy !== 2'd0) begin errors++; $display("FAIL flush.cleared got occ %0d exp 0", occupancy); end
            end
            if (c == 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
                    errors++;
                    $display("FAIL flush.after got v%b d%h exp v1 d5A", out_valid, out_data);
                end
            end
            clock_edge();
        end
    endtask

    task automatic test_full_pass();
        drain();
        for (int c = 0; c < 9; c++) begin
            set_inputs(1'b1, 8'($urandom), c >= 3, 1'b0);
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL full.in_ready c%0d got %b exp %b", c, in_ready, exp_ir); end
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL full.out_valid c%0d got %b exp %b", c, out_valid, exp_ov); end
            checks++; if (out_data !== exp_od) begin errors++; $display("FAIL full.out_data c%0d got %h exp %h", c, out_data, exp_od); end
            if (c >= 3) begin
                checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b1 || occupancy !== 2'd3) begin
                    errors++;
                    $display("FAIL full.pass c%0d got rdy%b v%b occ%0d exp rdy1 v1 occ3", c, in_ready, out_valid, occupancy);
                end
            end
            clock_edge();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_inputs(($urandom % 4) != 0, 8'($urandom), ($urandom % 10) < 7,
                       ($urandom % 20) == 0);
            checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL rand.in_ready c%0d got %b exp %b", c, in_ready, exp_ir); end
            checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rand.out_valid c%0d got %b exp %b", c, out_valid, exp_ov); end
            checks++; if (out_data !== exp_od) begin errors++; $display("FAIL rand.out_data c%0d got %h exp %h", c, out_data, exp_od); end
            checks++; if (occupancy !== exp_occ) begin errors++; $display("FAIL rand.occupancy c%0d got %0d exp %0d", c, occupancy, exp_occ); end
            clock_edge();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_flush();
        test_full_pass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
